spindle_contactor_seq: RTL and testbench

//   Actuator-side responder for the lathe run-control output: takes the run

---
 rtl/spindle_contactor_seq_if.sv | 25 ++
 rtl/spindle_contactor_seq.sv | 162 ++++++++++++++++
 tb/tb_spindle_contactor_seq.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/spindle_contactor_seq_if.sv
// Signal bundle between the run-control side and the spindle contactor sequencer.
// master = controller/plant side, slave = sequencer.
interface spindle_contactor_seq_if;
    logic       ena;
    logic       run_req;
    logic       aux_fb;
    logic       estop_n;
    logic       fault_clr;
    logic       coil_on;
    logic       running;
    logic       ready;
    logic       fault;
    logic [1:0] fault_code;
    logic [2:0] state_dbg;

    modport master (
        output ena, run_req, aux_fb, estop_n, fault_clr,
        input  coil_on, running, ready, fault, fault_code, state_dbg
    );

    modport slave (
        input  ena, run_req, aux_fb, estop_n, fault_clr,
        output coil_on, running, ready, fault, fault_code, state_dbg
    );
endinterface

// File: rtl/spindle_contactor_seq.sv
// Spindle contactor sequencer: engage/release handshakes on the aux contact, coast-down
// lockout and restart interlock. Define WELD_DETECT_EN to add IDLE welded-contact detection.
module spindle_contactor_seq #(
    parameter int FB_TIMEOUT  = 5_000_000,
    parameter int RUNDOWN     = 150_000_000,
    parameter int SYNC_STAGES = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    spindle_contactor_seq_if.slave bus
);

    localparam int CNT_MAX = (FB_TIMEOUT > RUNDOWN) ? FB_TIMEOUT : RUNDOWN;
    localparam int CW      = $clog2(CNT_MAX) + 1;
    localparam logic [CW-1:0] FB_LAST  = CW'(FB_TIMEOUT - 1);
    localparam logic [CW-1:0] RUN_LAST = CW'(RUNDOWN - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ENGAGE  = 3'd1,
        S_RUN     = 3'd2,
        S_RELEASE = 3'd3,
        S_COAST   = 3'd4,
        S_FAULT   = 3'd5
    } state_t;

    logic [SYNC_STAGES-1:0] fb_sync, est_sync, clr_sync;
    logic                   fb_s, est_s, clr_s;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [1:0]    code_q, code_nxt;
    logic          armed, armed_nxt;
    logic          coil_q, running_q, ready_q, fault_q;

    // The estop chain resets to 0 so the FSM treats the machine as stopped until
    // the real estop_n level has propagated through the synchroniser.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fb_sync  <= '0;
            est_sync <= '0;
            clr_sync <= '0;
        end else if (bus.ena) begin
            fb_sync  <= {fb_sync[SYNC_STAGES-2:0],  bus.aux_fb};
            est_sync <= {est_sync[SYNC_STAGES-2:0], bus.estop_n};
            clr_sync <= {clr_sync[SYNC_STAGES-2:0], bus.fault_clr};
        end
    end

    assign fb_s  = fb_sync[SYNC_STAGES-1];
    assign est_s = est_sync[SYNC_STAGES-1];
    assign clr_s = clr_sync[SYNC_STAGES-1];

`ifdef WELD_DETECT_EN
    logic [CW-1:0] weld_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            weld_cnt <= '0;
        end else if (bus.ena) begin
            if (state == S_IDLE && fb_s) begin
                if (weld_cnt != '1) weld_cnt <= weld_cnt + 1'b1;
            end else begin
                weld_cnt <= '0;
            end
        end
    end
`endif

    // NOTE: every variable gets a default before the case so no latch is inferred.
    always_comb begin
        state_nxt = state;
        code_nxt  = code_q;
        unique case (state)
            S_IDLE: begin
`ifdef WELD_DETECT_EN
                if (fb_s && weld_cnt == FB_LAST) begin
                    state_nxt = S_FAULT;
                    code_nxt  = 2'd3;
                end else if (bus.run_req && armed && est_s && !fb_s) begin
                    state_nxt = S_ENGAGE;
                end
`else
                if (bus.run_req && armed && est_s) state_nxt = S_ENGAGE;
`endif
            end
            S_ENGAGE: begin
                if (!est_s || !bus.run_req) state_nxt = S_RELEASE;
                else if (fb_s)              state_nxt = S_RUN;
                else if (cnt == FB_LAST) begin
                    state_nxt = S_FAULT;
                    code_nxt  = 2'd1;
                end
            end
            S_RUN: begin
                if (!est_s || !bus.run_req) state_nxt = S_RELEASE;
                else if (!fb_s) begin
                    state_nxt = S_FAULT;
                    code_nxt  = 2'd2;
                end
            end
            S_RELEASE: begin
                if (!fb_s) state_nxt = S_COAST;
                else if (cnt == FB_LAST) begin
                    state_nxt = S_FAULT;
                    code_nxt  = 2'd3;
                end
            end
            S_COAST: begin
                if (cnt == RUN_LAST) state_nxt = S_IDLE;
            end
            S_FAULT: begin
                if (clr_s && !bus.run_req && !fb_s) begin
                    state_nxt = S_COAST;
                    code_nxt  = 2'd0;
                end
            end
            default: state_nxt = S_IDLE;
        endcase

        armed_nxt = (state == S_IDLE) && (state_nxt == S_IDLE) && (armed || !bus.run_req);

        if (state_nxt != state)
            cnt_nxt = '0;
        else if ((state == S_ENGAGE || state == S_RELEASE || state == S_COAST) && cnt != '1)
            cnt_nxt = cnt + 1'b1;
        else
            cnt_nxt = cnt;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            cnt       <= '0;
            code_q    <= 2'd0;
            armed     <= 1'b0;
            coil_q    <= 1'b0;
            running_q <= 1'b0;
            ready_q   <= 1'b0;
            fault_q   <= 1'b0;
        end else if (bus.ena) begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            code_q    <= code_nxt;
            armed     <= armed_nxt;
            coil_q    <= (state_nxt == S_ENGAGE) || (state_nxt == S_RUN);
            running_q <= (state_nxt == S_RUN);
            ready_q   <= armed_nxt;
            fault_q   <= (state_nxt == S_FAULT);
        end
    end

    // Raw estop_n gates the coil so a stop never waits on the synchroniser.
    assign bus.coil_on    = coil_q & bus.estop_n;
    assign bus.running    = running_q;
    assign bus.ready      = ready_q;
    assign bus.fault      = fault_q;
    assign bus.fault_code = code_q;
    assign bus.state_dbg  = state;

endmodule

// File: tb/tb_spindle_contactor_seq.sv
// Directed bench for spindle_contactor_seq with FB_TIMEOUT=8, RUNDOWN=16, SYNC_STAGES=2.
// Weld-detect expectations follow WELD_DETECT_EN.
module tb_spindle_contactor_seq;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    spindle_contactor_seq_if bus();

    spindle_contactor_seq #(
        .FB_TIMEOUT (8),
        .RUNDOWN    (16),
        .SYNC_STAGES(2)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bus.ena       = 1'b1;
        bus.run_req   = 1'b1;
        bus.aux_fb    = 1'b0;
        bus.estop_n   = 1'b1;
        bus.fault_clr = 1'b0;

        // Reset with run_req already high: no start until it is seen low.
        tick(3);
        check("rst_coil",  bus.coil_on,    0);
        check("rst_state", bus.state_dbg,  0);
        check("rst_ready", bus.ready,      0);
        check("rst_code",  bus.fault_code, 0);
        reset = 1'b0;
        tick(4);
        check("held_req_coil",  bus.coil_on, 0);
        check("held_req_ready", bus.ready,   0);
        bus.run_req = 1'b0;
        tick(1);
        check("armed_ready", bus.ready, 1);
        bus.run_req = 1'b1;
        tick(1);
        check("engage_coil",  bus.coil_on,   1);
        check("engage_state", bus.state_dbg, 1);
        check("engage_ready", bus.ready,     0);

        // Normal cycle: feedback after 3 cycles, RUN after the sync delay.
        tick(2);
        bus.aux_fb = 1'b1;
        tick(2);
        check("fb_sync_wait", bus.running, 0);
        tick(1);
        check("run_running", bus.running,   1);
        check("run_state",   bus.state_dbg, 2);
        bus.run_req = 1'b0;
        #1;
        check("stop_coil_before", bus.coil_on, 1);
        tick(1);
        check("stop_coil",  bus.coil_on,   0);
        check("stop_state", bus.state_dbg, 3);
        bus.aux_fb = 1'b0;
        tick(2);
        check("release_wait", bus.state_dbg, 3);
        tick(1);
        check("coast_enter", bus.state_dbg, 4);
        bus.run_req = 1'b1;
        tick(15);
        check("coast_lock_state", bus.state_dbg, 4);
        check("coast_lock_coil",  bus.coil_on,   0);
        bus.run_req = 1'b0;
        tick(1);
        check("coast_done", bus.state_dbg, 0);
        tick(1);
        check("rearm_ready", bus.ready, 1);
        bus.run_req = 1'b1;
        tick(1);
        check("restart_coil", bus.coil_on, 1);

        // Engage timeout: no feedback for 8 ENGAGE cycles.
        tick(7);
        check("eto_pending", bus.state_dbg, 1);
        tick(1);
        check("eto_fault", bus.fault,      1);
        check("eto_code",  bus.fault_code, 1);
        check("eto_coil",  bus.coil_on,    0);
        bus.fault_clr = 1'b1;
        tick(3);
        check("eto_clr_blocked", bus.state_dbg, 5);
        bus.run_req = 1'b0;
        tick(1);
        check("eto_clr_state", bus.state_dbg,  4);
        check("eto_clr_code",  bus.fault_code, 0);
        check("eto_clr_fault", bus.fault,      0);
        bus.fault_clr = 1'b0;
        tick(16);
        check("eto_idle", bus.state_dbg, 0);
        tick(1);
        check("eto_ready", bus.ready, 1);

        // Dropout while running.
        bus.run_req = 1'b1;
        tick(1);
        bus.aux_fb = 1'b1;
        tick(3);
        check("drop_run", bus.running, 1);
        bus.aux_fb = 1'b0;
        tick(2);
        check("drop_wait", bus.running, 1);
        tick(1);
        check("drop_code",    bus.fault_code, 2);
        check("drop_coil",    bus.coil_on,    0);
        check("drop_running", bus.running,    0);
        bus.fault_clr = 1'b1;
        tick(4);
        check("drop_clr_blocked", bus.state_dbg,  5);
        check("drop_code_held",   bus.fault_code, 2);
        bus.run_req = 1'b0;
        tick(1);
        check("drop_clr_coast", bus.state_dbg, 4);
        bus.fault_clr = 1'b0;
        tick(16);
        check("drop_idle", bus.state_dbg, 0);
        tick(1);
        check("drop_ready", bus.ready, 1);

        // Emergency stop while running.
        bus.run_req = 1'b1;
        tick(1);
        bus.aux_fb = 1'b1;
        tick(3);
        check("es_run", bus.running, 1);
        bus.estop_n = 1'b0;
        #1;
        check("es_coil_kill", bus.coil_on, 0);
        check("es_still_run", bus.running, 1);
        tick(2);
        check("es_sync_wait", bus.state_dbg, 2);
        tick(1);
        check("es_release", bus.state_dbg, 3);
        bus.aux_fb = 1'b0;
        tick(3);
        check("es_coast", bus.state_dbg, 4);
        bus.estop_n = 1'b1;
        tick(16);
        check("es_idle", bus.state_dbg, 0);
        tick(4);
        check("es_no_restart_coil",  bus.coil_on, 0);
        check("es_no_restart_ready", bus.ready,   0);
        bus.run_req = 1'b0;
        tick(1);
        check("es_rearm", bus.ready, 1);
        bus.run_req = 1'b1;
        tick(1);
        check("es_restart", bus.coil_on, 1);

        // Reset mid-operation: coil drops at once, interlock blocks restart.
        reset = 1'b1;
        #1;
        check("midrst_coil",  bus.coil_on,   0);
        check("midrst_state", bus.state_dbg, 0);
        tick(1);
        reset = 1'b0;
        tick(4);
        check("midrst_no_restart", bus.coil_on, 0);

        // ena low freezes the sequencer but not the estop kill.
        bus.run_req = 1'b0;
        tick(1);
        check("ena_armed", bus.ready, 1);
        bus.ena     = 1'b0;
        bus.run_req = 1'b1;
        tick(3);
        check("ena_hold_idle", bus.state_dbg, 0);
        bus.ena = 1'b1;
        tick(1);
        check("ena_engage", bus.state_dbg, 1);
        bus.ena = 1'b0;
        tick(12);
        check("ena_hold_engage", bus.state_dbg, 1);
        check("ena_hold_coil",   bus.coil_on,   1);
        bus.estop_n = 1'b0;
        #1;
        check("ena_estop_kill", bus.coil_on, 0);
        bus.estop_n = 1'b1;
        bus.ena     = 1'b1;
        bus.run_req = 1'b0;
        tick(1);
        check("ena_release", bus.state_dbg, 3);
        tick(17);
        check("ena_back_idle", bus.state_dbg, 0);

        // Feedback closed with the coil off in IDLE.
        bus.aux_fb = 1'b1;
        tick(12);
`ifdef WELD_DETECT_EN
        check("weld_fault", bus.fault,      1);
        check("weld_code",  bus.fault_code, 3);
`else
        check("weld_fault", bus.fault,     0);
        check("weld_state", bus.state_dbg, 0);
`endif
        bus.aux_fb = 1'b0;
        tick(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
